// File: rtl/pipe_arith_pkg.sv
// Shared helpers for the segmented arithmetic pipelines: segment sizing
// functions and the operation encoding used by the add/sub datapath.
package pipe_arith_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Every segment, including the short last one, must keep at least one bit.
  localparam int MIN_SEG_W = 1;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int last_seg_w(input int width, input int nseg);
    return width - (nseg - 1) * ceil_div(width, nseg);
  endfunction

  // Width of segment k: full SEG_W for all but the last, remainder for the last.
  function automatic int seg_w(input int width, input int nseg, input int k);
    return (k == nseg - 1) ? last_seg_w(width, nseg) : ceil_div(width, nseg);
  endfunction

  function automatic int seg_lo(input int width, input int nseg, input int k);
    return k * ceil_div(width, nseg);
  endfunction

endpackage

// File: rtl/pipe_addsub_stage.sv
// One segment of the pipelined adder: registered {cout, sum} = a + b + cin,
// updated only when the pipeline advances.
module pipe_addsub_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // NOTE: non-blocking assignments so every stage samples its neighbours'
  // values from before the edge, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      {cout, sum} <= '0;
    end else if (en) begin
      {cout, sum} <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end
  end

endmodule

// File: rtl/pipe_addsub_seg.sv
// Segmented pipelined adder/subtractor with valid/ready handshake. Segment k
// is added in stage k; operands are skewed in and sums deskewed out.
module pipe_addsub_seg
  import pipe_arith_pkg::*;
#(
  parameter int WIDTH = 129,
  parameter int NSEG  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int SEG_W  = ceil_div(WIDTH, NSEG);
  localparam int LAST_W = last_seg_w(WIDTH, NSEG);

  if (WIDTH < 2 || NSEG < 1 || NSEG > WIDTH || LAST_W < MIN_SEG_W || SEG_W < MIN_SEG_W)
  begin : g_param_check
    $error("pipe_addsub_seg: WIDTH/NSEG leave an empty last segment");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [NSEG-1:0]  valid_r;
  logic [NSEG:0]    carry;

  // The whole pipe moves as one; a held result freezes everything behind it.
  assign adv     = !valid_r[NSEG-1] | o_ready;
  assign i_ready = adv;
  assign o_valid = valid_r[NSEG-1];
  assign o_cout  = carry[NSEG];

  // NOTE: both outputs get a default first so no path leaves them unassigned
  // and no latch is inferred.
  always_comb begin
    b_eff = i_b;
    c0    = i_cin;
    if (op_e'(i_sub) == OP_SUB) begin
      b_eff = ~i_b;
      c0    = 1'b1;
    end
  end

  assign carry[0] = c0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (adv) begin
      valid_r[0] <= i_valid;
      for (int i = 1; i < NSEG; i++) begin
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int LO      = seg_lo(WIDTH, NSEG, k);
    localparam int SW      = seg_w(WIDTH, NSEG, k);
    localparam int DLY_OUT = NSEG - 1 - k;

    logic [SW-1:0] seg_a;
    logic [SW-1:0] seg_b;
    logic [SW-1:0] seg_sum;

    if (k == 0) begin : g_noskew
      assign seg_a = i_a[LO +: SW];
      assign seg_b = b_eff[LO +: SW];
    end else begin : g_skew
      logic [SW-1:0] a_dl [k];
      logic [SW-1:0] b_dl [k];

      // NOTE: skew registers are deliberately not reset; their contents only
      // matter when a valid bit travels alongside them.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_dl[0] <= i_a[LO +: SW];
          b_dl[0] <= b_eff[LO +: SW];
          for (int i = 1; i < k; i++) begin
            a_dl[i] <= a_dl[i-1];
            b_dl[i] <= b_dl[i-1];
          end
        end
      end

      assign seg_a = a_dl[k-1];
      assign seg_b = b_dl[k-1];
    end

    pipe_addsub_stage #(
      .W (SW)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .a    (seg_a),
      .b    (seg_b),
      .cin  (carry[k]),
      .sum  (seg_sum),
      .cout (carry[k+1])
    );

    if (DLY_OUT == 0) begin : g_nodeskew
      assign o_sum[LO +: SW] = seg_sum;
    end else begin : g_deskew
      logic [SW-1:0] s_dl [DLY_OUT];

      // Deskew registers feed o_sum directly, so they clear on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DLY_OUT; i++) begin
            s_dl[i] <= '0;
          end
        end else if (adv) begin
          s_dl[0] <= seg_sum;
          for (int i = 1; i < DLY_OUT; i++) begin
            s_dl[i] <= s_dl[i-1];
          end
        end
      end

      assign o_sum[LO +: SW] = s_dl[DLY_OUT-1];
    end
  end

endmodule

// File: tb/tb_pipe_addsub_seg.sv
// Self-checking bench for pipe_addsub_seg: directed table, random stream with
// a scoreboard, stall, mid-flight reset, and small-width latency checks.
module tb_pipe_addsub_seg;
  import pipe_arith_pkg::*;

  localparam int W    = 129;
  localparam int NSEG = 2;
  localparam int SW   = 16;

  typedef logic [W:0] cw_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    logic          sub;
    logic          cin;
    logic [SW-1:0] sum;
    logic          cout;
  } svec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid, i_ready, i_sub, i_cin;
  logic         o_valid, o_ready, o_cout;
  logic [W-1:0] i_a, i_b, o_sum;

  logic          s_valid, s_sub, s_cin;
  logic [SW-1:0] s_a, s_b, s4_sum, s1_sum;
  logic          s4_valid, s1_valid, s4_cout, s1_cout, s4_ready, s1_ready;

  always #5 clk = ~clk;

  pipe_addsub_seg #(.WIDTH(W), .NSEG(NSEG)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_a(i_a), .i_b(i_b),
    .i_sub(i_sub), .i_cin(i_cin), .o_valid(o_valid), .o_ready(o_ready),
    .o_sum(o_sum), .o_cout(o_cout)
  );

  pipe_addsub_seg #(.WIDTH(SW), .NSEG(4)) dut_16x4 (
    .clk(clk), .rst(rst), .i_valid(s_valid), .i_ready(s4_ready), .i_a(s_a), .i_b(s_b),
    .i_sub(s_sub), .i_cin(s_cin), .o_valid(s4_valid), .o_ready(1'b1),
    .o_sum(s4_sum), .o_cout(s4_cout)
  );

  pipe_addsub_seg #(.WIDTH(SW), .NSEG(1)) dut_16x1 (
    .clk(clk), .rst(rst), .i_valid(s_valid), .i_ready(s1_ready), .i_a(s_a), .i_b(s_b),
    .i_sub(s_sub), .i_cin(s_cin), .o_valid(s1_valid), .o_ready(1'b1),
    .o_sum(s1_sum), .o_cout(s1_cout)
  );

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  bit           chk_lat, chk_stall, hold_prev;
  logic [W-1:0] held_sum, drv_sum;
  logic         held_cout, drv_cout;
  exp_t         sb[$];
  vec_t         tbl[8];
  svec_t        stbl[3];

  task automatic check(input string name, input cw_t got, input cw_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: plain modular arithmetic; subtract reports "no borrow" as carry.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    exp_t e;
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
    end else begin
      {e.cout, e.sum} = {1'b0, a} + {1'b0, b} + cw_t'(cin);
    end
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin, input logic [W-1:0] es, input logic ec);
    i_valid  = v;
    i_a      = a;
    i_b      = b;
    i_sub    = sub;
    i_cin    = cin;
    drv_sum  = es;
    drv_cout = ec;
  endtask

  task automatic drive_rand();
    logic [W-1:0] a, b;
    logic         sub, cin;
    exp_t         e;
    a   = rnd_w();
    b   = rnd_w();
    if ($urandom_range(0, 3) == 0) a[64:0] = '1;
    if ($urandom_range(0, 7) == 0) b = a;
    sub = 1'($urandom_range(0, 1));
    cin = 1'($urandom_range(0, 1));
    e   = model(a, b, sub, cin);
    drive(1'b1, a, b, sub, cin, e.sum, e.cout);
  endtask

  // One clock cycle: observe handshakes mid-cycle, then advance to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (rst) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (chk_stall) check("stall_i_ready", cw_t'(i_ready), cw_t'(1'b0));
      if (hold_prev && o_valid && !o_ready) begin
        check("hold_sum", cw_t'(o_sum), cw_t'(held_sum));
        check("hold_cout", cw_t'(o_cout), cw_t'(held_cout));
      end
      hold_prev = o_valid && !o_ready;
      held_sum  = o_sum;
      held_cout = o_cout;
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_beat: got sum %0h, expected no beat (cycle %0d)", o_sum, cyc);
        end else begin
          e = sb.pop_front();
          check("sum", cw_t'(o_sum), cw_t'(e.sum));
          check("cout", cw_t'(o_cout), cw_t'(e.cout));
          if (chk_lat) check("latency", cw_t'(cyc - e.cyc), cw_t'(NSEG));
        end
      end
      if (i_valid && i_ready) sb.push_back('{drv_sum, drv_cout, cyc});
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    check("drain_pending", cw_t'(sb.size()), cw_t'(0));
  endtask

  initial begin
    tbl[0] = '{{W{1'b1}}, W'(1), 1'b0, 1'b0, W'(0), 1'b1};
    tbl[1] = '{W'(5), W'(7), 1'b1, 1'b0, {{(W-1){1'b1}}, 1'b0}, 1'b0};
    tbl[2] = '{W'(7), W'(5), 1'b1, 1'b0, W'(2), 1'b1};
    tbl[3] = '{{64'h0, {65{1'b1}}}, W'(1), 1'b0, 1'b0, {63'h0, 1'b1, 65'h0}, 1'b0};
    tbl[4] = '{W'(0), W'(0), 1'b0, 1'b1, W'(1), 1'b0};
    tbl[5] = '{{W{1'b1}}, {W{1'b1}}, 1'b0, 1'b1, {W{1'b1}}, 1'b1};
    tbl[6] = '{{1'b1, 64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98},
               {1'b1, 64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98},
               1'b1, 1'b0, W'(0), 1'b1};
    tbl[7] = '{W'(0), W'(1), 1'b1, 1'b1, {W{1'b1}}, 1'b0};

    stbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    stbl[1] = '{16'h1234, 16'h1235, 1'b1, 1'b0, 16'hFFFF, 1'b0};
    stbl[2] = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h0000, 1'b1};

    rst = 1'b1;
    o_ready = 1'b1;
    chk_lat = 1'b0;
    chk_stall = 1'b0;
    hold_prev = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    s_valid = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; s_cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_o_valid", cw_t'(o_valid), cw_t'(1'b0));
    check("rst_o_sum", cw_t'(o_sum), cw_t'(0));
    check("rst_o_cout", cw_t'(o_cout), cw_t'(1'b0));
    check("rst_i_ready", cw_t'(i_ready), cw_t'(1'b1));
    check("rst_i_ready_16x4", cw_t'(s4_ready), cw_t'(1'b1));
    @(negedge clk);

    // Directed table, one beat at a time, latency checked.
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, tbl[i].sum, tbl[i].cout);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      drain();
    end

    // Back-to-back random stream with mixed modes.
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    drain();

    // Stall with a full pipe, then release.
    chk_lat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      tick();
    end
    drive_rand();
    o_ready = 1'b0;
    chk_stall = 1'b1;
    repeat (5) tick();
    chk_stall = 1'b0;
    o_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      drive_rand();
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    drain();
    repeat (3) tick();

    // Reset with two beats in flight; nothing stale may come out.
    drive_rand();
    tick();
    drive_rand();
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_o_valid", cw_t'(o_valid), cw_t'(1'b0));
    check("post_rst_o_sum", cw_t'(o_sum), cw_t'(0));
    repeat (6) tick();

    // Narrow configurations: NSEG=4 and NSEG=1 latency and values.
    for (int v = 0; v < 3; v++) begin
      int lat4, lat1;
      lat4 = -1;
      lat1 = -1;
      s_a = stbl[v].a; s_b = stbl[v].b; s_sub = stbl[v].sub; s_cin = stbl[v].cin;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        #1;
        if (s4_valid && lat4 < 0) begin
          lat4 = c;
          check("sum_16x4", cw_t'(s4_sum), cw_t'(stbl[v].sum));
          check("cout_16x4", cw_t'(s4_cout), cw_t'(stbl[v].cout));
        end
        if (s1_valid && lat1 < 0) begin
          lat1 = c;
          check("sum_16x1", cw_t'(s1_sum), cw_t'(stbl[v].sum));
          check("cout_16x1", cw_t'(s1_cout), cw_t'(stbl[v].cout));
        end
        @(negedge clk);
      end
      check("latency_16x4", cw_t'(lat4), cw_t'(4));
      check("latency_16x1", cw_t'(lat1), cw_t'(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
